// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, status codes, sequencer states.
// Optional Y86_SEQ_STEP_EN adds the single-step wait state.
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_PCUPD,
`ifdef Y86_SEQ_STEP_EN
        S_STEPWAIT,
`endif
        S_HALTED
    } state_t;

endpackage

// File: rtl/y86_next_pc.sv
// Next-PC select: call/taken jXX -> valC, ret -> valM, everything else -> valP.
// Latency: combinational. Backpressure: none.
module y86_next_pc
    import y86_pkg::*;
(
    input  logic [3:0]  icode,
    input  logic        cond,
    input  logic [63:0] valC,
    input  logic [63:0] valM,
    input  logic [63:0] valP,
    output logic [63:0] new_pc
);

    always_comb begin
        new_pc = valP;
        case (icode)
            ICALL:   new_pc = valC;
            IJXX:    new_pc = cond ? valC : valP;
            IRET:    new_pc = valM;
            default: new_pc = valP;
        endcase
    end

endmodule

// File: rtl/y86_seq_ctrl.sv
// Sequential Y86-64 control FSM: one stage per clock, owns PC, status and counters.
// Latency: 6 clocks per instruction. Backpressure: none; Y86_SEQ_STEP_EN gates each instruction on step.
module y86_seq_ctrl
    import y86_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'd0,
    parameter int          CNT_W    = 32
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef Y86_SEQ_STEP_EN
    input  logic             step,
`endif
    input  logic [3:0]       icode,
    input  logic             cond,
    input  logic [63:0]      valC,
    input  logic [63:0]      valP,
    input  logic [63:0]      valM,
    input  logic             hlt,
    input  logic             in_mem,
    input  logic             in_inst,
    input  logic             dmem_err,
    output logic [63:0]      PC,
    output logic             fetch_en,
    output logic             decode_en,
    output logic             exec_en,
    output logic             mem_en,
    output logic             wb_en,
    output logic [2:0]       stat,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
);

    state_t      state, state_nxt;
    logic [63:0] new_pc;
    logic        cycle_cnt_en;
    logic        step_go;

    y86_next_pc u_next_pc (
        .icode  (icode),
        .cond   (cond),
        .valC   (valC),
        .valM   (valM),
        .valP   (valP),
        .new_pc (new_pc)
    );

`ifdef Y86_SEQ_STEP_EN
    // Rising-edge detect so a step held across entry into STEPWAIT is not consumed.
    logic step_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) step_q <= 1'b0;
        else        step_q <= step;
    end
    assign step_go = step && !step_q;
`else
    assign step_go = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_FETCH;
            S_FETCH:  state_nxt = (in_mem || in_inst || hlt) ? S_HALTED : S_DECODE;
            S_DECODE: state_nxt = S_EXEC;
            S_EXEC:   state_nxt = S_MEM;
            S_MEM:    state_nxt = dmem_err ? S_HALTED : S_WB;
            S_WB:     state_nxt = S_PCUPD;
`ifdef Y86_SEQ_STEP_EN
            S_PCUPD:    state_nxt = S_STEPWAIT;
            S_STEPWAIT: if (step_go) state_nxt = S_FETCH;
`else
            S_PCUPD:  state_nxt = step_go ? S_FETCH : S_FETCH;
`endif
            S_HALTED: state_nxt = S_HALTED;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        fetch_en     = (state == S_FETCH);
        decode_en    = (state == S_DECODE);
        exec_en      = (state == S_EXEC);
        mem_en       = (state == S_MEM);
        wb_en        = (state == S_WB);
        done         = (state == S_HALTED);
        busy         = (state != S_IDLE) && (state != S_HALTED);
        cycle_cnt_en = busy;
`ifdef Y86_SEQ_STEP_EN
        if (state == S_STEPWAIT) cycle_cnt_en = 1'b0;
`endif
    end

    // PC, status and retired count only move in the state that owns them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            PC        <= RESET_PC;
            stat      <= STAT_AOK;
            instr_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    PC        <= RESET_PC;
                    stat      <= STAT_AOK;
                    instr_cnt <= '0;
                end
                S_FETCH: begin
                    if (in_mem)       stat <= STAT_ADR;
                    else if (in_inst) stat <= STAT_INS;
                    else if (hlt) begin
                        stat <= STAT_HLT;
                        if (instr_cnt != '1) instr_cnt <= instr_cnt + CNT_W'(1);
                    end
                end
                S_MEM: if (dmem_err) stat <= STAT_ADR;
                S_PCUPD: begin
                    PC <= new_pc;
                    if (instr_cnt != '1) instr_cnt <= instr_cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                    cycle_cnt <= '0;
        else if (state == S_IDLE && start)             cycle_cnt <= '0;
        else if (cycle_cnt_en && cycle_cnt != '1)      cycle_cnt <= cycle_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_y86_seq_ctrl.sv
// Directed bench for y86_seq_ctrl: inputs driven and outputs sampled on the falling edge.
module tb_y86_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  icode = 4'h1;
    logic        cond = 1'b0;
    logic [63:0] valC = '0;
    logic [63:0] valP = '0;
    logic [63:0] valM = '0;
    logic        hlt = 1'b0;
    logic        in_mem = 1'b0;
    logic        in_inst = 1'b0;
    logic        dmem_err = 1'b0;
    logic [63:0] PC;
    logic        fetch_en, decode_en, exec_en, mem_en, wb_en;
    logic [2:0]  stat;
    logic        busy, done;
    logic [31:0] cycle_cnt, instr_cnt;

    int total = 0;
    int bad = 0;

    y86_seq_ctrl #(.RESET_PC(64'd0), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .icode(icode), .cond(cond), .valC(valC), .valP(valP), .valM(valM),
        .hlt(hlt), .in_mem(in_mem), .in_inst(in_inst), .dmem_err(dmem_err),
        .PC(PC), .fetch_en(fetch_en), .decode_en(decode_en), .exec_en(exec_en),
        .mem_en(mem_en), .wb_en(wb_en), .stat(stat), .busy(busy), .done(done),
        .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_inputs();
        start = 0; icode = 4'h1; cond = 0; valC = '0; valP = '0; valM = '0;
        hlt = 0; in_mem = 0; in_inst = 0; dmem_err = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        rst_n = 0;
        #3 rst_n = 1;
    endtask

    // Leaves the DUT in FETCH at a falling edge.
    task automatic launch();
        start = 1;
        tick(1);
        start = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        #7;
        total++; if (PC !== 64'd0) begin bad++; $display("FAIL reset_pc got=%h exp=0", PC); end
        total++; if ({fetch_en, decode_en, exec_en, mem_en, wb_en} !== 5'b0) begin bad++; $display("FAIL reset_en got=%b exp=00000", {fetch_en, decode_en, exec_en, mem_en, wb_en}); end
        total++; if (stat !== 3'd1) begin bad++; $display("FAIL reset_stat got=%0d exp=1", stat); end
        total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL reset_busy_done got=%b exp=00", {busy, done}); end
        total++; if (cycle_cnt !== 0 || instr_cnt !== 0) begin bad++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", cycle_cnt, instr_cnt); end
        @(negedge clk);
        rst_n = 1;
        tick(1);
    endtask

    task automatic test_irmovq_halt();
        do_reset();
        icode = 4'h3; valP = 64'd10; valC = 64'h77;
        tick(1);
        launch();
        total++; if (fetch_en !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL launch_fetch got=%b%b exp=11", fetch_en, busy); end
        tick(1);
        start = 1;
        tick(1);
        start = 0;
        total++; if (exec_en !== 1'b1 || PC !== 64'd0) begin bad++; $display("FAIL start_busy_ignored exec_en=%b pc=%h exp=1/0", exec_en, PC); end
        tick(4);
        total++; if (PC !== 64'd10 || fetch_en !== 1'b1) begin bad++; $display("FAIL irmovq_pc got=%h fe=%b exp=a/1", PC, fetch_en); end
        icode = 4'h0; hlt = 1;
        tick(1);
        hlt = 0;
        total++; if (done !== 1'b1 || busy !== 1'b0 || stat !== 3'd2) begin bad++; $display("FAIL halt_state done=%b busy=%b stat=%0d exp=1/0/2", done, busy, stat); end
        total++; if (instr_cnt !== 32'd2 || cycle_cnt !== 32'd7) begin bad++; $display("FAIL halt_counts instr=%0d cyc=%0d exp=2/7", instr_cnt, cycle_cnt); end
        total++; if (PC !== 64'd10) begin bad++; $display("FAIL halt_pc got=%h exp=a", PC); end
        start = 1;
        tick(1);
        start = 0;
        tick(2);
        total++; if (done !== 1'b1 || fetch_en !== 1'b0 || PC !== 64'd10 || cycle_cnt !== 32'd7) begin bad++; $display("FAIL halted_sticky done=%b fe=%b pc=%h cyc=%0d exp=1/0/a/7", done, fetch_en, PC, cycle_cnt); end
    endtask

    task automatic test_jxx();
        for (int c = 1; c >= 0; c--) begin
            do_reset();
            icode = 4'h7; valC = 64'h40; valP = 64'd9; cond = 1'b0;
            tick(1);
            launch();
            tick(5);
            cond = c[0];
            tick(1);
            cond = ~c[0];
            total++; if (PC !== (c == 1 ? 64'h40 : 64'd9)) begin bad++; $display("FAIL jxx_cond%0d got=%h exp=%h", c, PC, (c == 1 ? 64'h40 : 64'd9)); end
        end
    endtask

    task automatic test_call_ret();
        do_reset();
        icode = 4'h8; valC = 64'h100; valP = 64'd10; valM = 64'h33;
        tick(1);
        launch();
        tick(6);
        total++; if (PC !== 64'h100) begin bad++; $display("FAIL call_pc got=%h exp=100", PC); end
        icode = 4'h9; valM = 64'h9; valC = 64'h55; valP = 64'h101;
        tick(6);
        total++; if (PC !== 64'h9 || instr_cnt !== 32'd2) begin bad++; $display("FAIL ret_pc got=%h instr=%0d exp=9/2", PC, instr_cnt); end
    endtask

    task automatic test_fetch_faults();
        do_reset();
        tick(1);
        launch();
        in_mem = 1; in_inst = 1; hlt = 1;
        tick(1);
        clear_inputs();
        total++; if (stat !== 3'd3 || done !== 1'b1) begin bad++; $display("FAIL fault_prio stat=%0d done=%b exp=3/1", stat, done); end
        total++; if (PC !== 64'd0 || instr_cnt !== 32'd0) begin bad++; $display("FAIL fault_pc_cnt pc=%h instr=%0d exp=0/0", PC, instr_cnt); end
        do_reset();
        tick(1);
        launch();
        in_inst = 1; hlt = 1;
        tick(1);
        clear_inputs();
        total++; if (stat !== 3'd4 || done !== 1'b1 || instr_cnt !== 32'd0) begin bad++; $display("FAIL fault_ins stat=%0d done=%b instr=%0d exp=4/1/0", stat, done, instr_cnt); end
    endtask

    task automatic test_dmem_err();
        logic wb_seen;
        wb_seen = 0;
        do_reset();
        icode = 4'h4; valP = 64'd10; dmem_err = 1;
        tick(1);
        launch();
        for (int i = 0; i < 6; i++) begin
            if (wb_en) wb_seen = 1;
            tick(1);
        end
        total++; if (wb_seen !== 1'b0) begin bad++; $display("FAIL dmem_wb got=%b exp=0", wb_seen); end
        total++; if (stat !== 3'd3 || done !== 1'b1) begin bad++; $display("FAIL dmem_stat stat=%0d done=%b exp=3/1", stat, done); end
        total++; if (instr_cnt !== 32'd0 || cycle_cnt !== 32'd4 || PC !== 64'd0) begin bad++; $display("FAIL dmem_cnt instr=%0d cyc=%0d pc=%h exp=0/4/0", instr_cnt, cycle_cnt, PC); end
    endtask

    task automatic test_async_reset();
        do_reset();
        icode = 4'h1; valP = 64'h20;
        tick(1);
        launch();
        tick(8);
        total++; if (exec_en !== 1'b1 || PC !== 64'h20) begin bad++; $display("FAIL pre_reset exec_en=%b pc=%h exp=1/20", exec_en, PC); end
        #1 rst_n = 0;
        #1;
        total++; if (PC !== 64'd0 || exec_en !== 1'b0 || busy !== 1'b0 || instr_cnt !== 32'd0 || cycle_cnt !== 32'd0) begin bad++; $display("FAIL async_reset pc=%h ee=%b busy=%b instr=%0d cyc=%0d exp=0/0/0/0/0", PC, exec_en, busy, instr_cnt, cycle_cnt); end
        #1 rst_n = 1;
        valP = 64'd2;
        tick(1);
        launch();
        tick(6);
        total++; if (PC !== 64'd2 || instr_cnt !== 32'd1 || stat !== 3'd1) begin bad++; $display("FAIL rerun pc=%h instr=%0d stat=%0d exp=2/1/1", PC, instr_cnt, stat); end
    endtask

    initial begin
        test_reset();
        test_irmovq_halt();
        test_jxx();
        test_call_ret();
        test_fetch_faults();
        test_dmem_err();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
